// File: rtl/wb_arch_state.sv
// Write-back architectural state: 32xDW GPR file with same-cycle write-to-read
// bypass on both ID read ports, plus the HI/LO pair and the LL/SC link bit.
module wb_arch_state #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_wd,
    input  logic          wb_wreg,
    input  logic [DW-1:0] wb_wdata,
    input  logic          wb_whilo,
    input  logic [DW-1:0] wb_hi,
    input  logic [DW-1:0] wb_lo,
    input  logic          wb_LLbit_we,
    input  logic          wb_LLbit_value,
    input  logic          flush,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          LLbit_o
);

    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0] gpr [NREG];
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          llbit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // A flush (exception/ERET) breaks any LL/SC sequence, so it beats a pending LLbit write.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit_q <= 1'b0;
        end else if (flush) begin
            llbit_q <= 1'b0;
        end else if (wb_LLbit_we) begin
            llbit_q <= wb_LLbit_value;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (re1 && wb_wreg && (wb_wd == raddr1)) begin
            rdata1 = wb_wdata;
        end else if (re1) begin
            rdata1 = gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (re2 && wb_wreg && (wb_wd == raddr2)) begin
            rdata2 = wb_wdata;
        end else if (re2) begin
            rdata2 = gpr[raddr2];
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign LLbit_o = llbit_q;

endmodule

// File: tb/tb_wb_arch_state.sv
// Directed scoreboard bench for wb_arch_state: expected values are queued when
// stimulus is driven and popped when the corresponding DUT output is sampled.
module tb_wb_arch_state;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wb_wd;
    logic          wb_wreg;
    logic [DW-1:0] wb_wdata;
    logic          wb_whilo;
    logic [DW-1:0] wb_hi;
    logic [DW-1:0] wb_lo;
    logic          wb_LLbit_we;
    logic          wb_LLbit_value;
    logic          flush;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    logic          LLbit_o;

    always #5 clk = ~clk;

    wb_arch_state #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .flush(flush),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    string         tag_q[$];
    logic [DW-1:0] exp_q[$];
    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;

    // Reference state, updated at each rising edge from the driven inputs.
    logic [DW-1:0] mdl_gpr [32];
    logic [DW-1:0] mdl_hi;
    logic [DW-1:0] mdl_lo;
    logic          mdl_ll;

    task automatic expect_val(input string tag, input logic [DW-1:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [DW-1:0] obs);
        string         tag;
        logic [DW-1:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_empty observed=%h required=queued_entry", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h required=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; wb_wd = '0; wb_wreg = 1'b0; wb_wdata = '0;
        wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl_gpr[i] = '0;
            mdl_hi = '0; mdl_lo = '0; mdl_ll = 1'b0;
        end else begin
            if (wb_wreg && wb_wd != 0) mdl_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin mdl_hi = wb_hi; mdl_lo = wb_lo; end
            if (flush) mdl_ll = 1'b0;
            else if (wb_LLbit_we) mdl_ll = wb_LLbit_value;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mdl_gpr[i] = '0;
        mdl_hi = '0; mdl_lo = '0; mdl_ll = 1'b0;
        idle();

        // Reset with active write-back and a bypass match: reads stay 0
        @(negedge clk);
        rst = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h0000_0077;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        expect_val("rst_rd1", '0); check(rdata1);
        expect_val("rst_rd2", '0); check(rdata2);
        tick();
        tick();
        @(negedge clk); idle();

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            re1 = 1'b1; raddr1 = AW'(i); re2 = 1'b1; raddr2 = AW'(31 - i);
            #1;
            expect_val("reset_rd1", '0); check(rdata1);
            expect_val("reset_rd2", '0); check(rdata2);
        end
        expect_val("reset_hi", '0); check(hi_o);
        expect_val("reset_lo", '0); check(lo_o);
        expect_val("reset_ll", '0); check(DW'(LLbit_o));

        // Same-cycle bypass on both ports, then readback from the array
        @(negedge clk); idle();
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        expect_val("bypass_rd1", 32'hDEAD_BEEF); check(rdata1);
        expect_val("bypass_rd2", 32'hDEAD_BEEF); check(rdata2);
        tick();
        @(negedge clk); wb_wreg = 1'b0; wb_wdata = '0;
        #1;
        expect_val("array_rd1", 32'hDEAD_BEEF); check(rdata1);
        expect_val("array_rd2", 32'hDEAD_BEEF); check(rdata2);

        // Bypass match with port 1 disabled
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h1111_1111;
        re1 = 1'b0; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        expect_val("bypass_dis_rd1", '0); check(rdata1);
        expect_val("bypass_en_rd2", 32'h1111_1111); check(rdata2);
        tick();

        // Write to r0 is discarded, and r0 never bypasses
        @(negedge clk); idle();
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h1234_5678;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        expect_val("r0_bypass_rd1", '0); check(rdata1);
        tick();
        @(negedge clk); idle();
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        expect_val("r0_rd1", '0); check(rdata1);
        expect_val("r0_rd2", '0); check(rdata2);

        // Disabled port returns 0, not the stored value
        @(negedge clk); idle();
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h0000_0055;
        tick();
        @(negedge clk); idle();
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
        #1;
        expect_val("r7_rd1", 32'h0000_0055); check(rdata1);
        expect_val("r7_dis_rd2", '0); check(rdata2);

        // Fill r1..r31 with random data, read back on both ports
        for (int i = 1; i < 32; i++) begin
            @(negedge clk); idle();
            wb_wreg = 1'b1; wb_wd = AW'(i); wb_wdata = $urandom;
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); idle();
            re1 = 1'b1; raddr1 = AW'(i); re2 = 1'b1; raddr2 = AW'((i + 13) % 32);
            #1;
            expect_val("fill_rd1", mdl_gpr[i]); check(rdata1);
            expect_val("fill_rd2", mdl_gpr[(i + 13) % 32]); check(rdata2);
        end

        // Write to one index does not bypass onto another
        @(negedge clk); idle();
        wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'hFEED_F00D;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd4;
        #1;
        expect_val("nomatch_rd1", mdl_gpr[9]); check(rdata1);
        expect_val("match_rd2", 32'hFEED_F00D); check(rdata2);
        tick();

        // HI/LO: one-cycle latency, then hold
        @(negedge clk); idle();
        wb_whilo = 1'b1; wb_hi = 32'hAAAA_0001; wb_lo = 32'h5555_FFFE;
        #1;
        expect_val("hi_before", '0); check(hi_o);
        expect_val("hi_after", 32'hAAAA_0001);
        expect_val("lo_after", 32'h5555_FFFE);
        tick();
        check(hi_o); check(lo_o);
        @(negedge clk); idle();
        wb_hi = 32'hFFFF_FFFF; wb_lo = 32'h0000_0000;
        expect_val("hi_hold", 32'hAAAA_0001);
        expect_val("lo_hold", 32'h5555_FFFE);
        tick();
        check(hi_o); check(lo_o);

        // LLbit set, flush priority, hold, clear
        @(negedge clk); idle();
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        expect_val("ll_set", 32'd1);
        tick(); check(DW'(LLbit_o));
        @(negedge clk); idle();
        flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        expect_val("ll_flush", 32'd0);
        tick(); check(DW'(LLbit_o));
        @(negedge clk); idle();
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        tick();
        @(negedge clk); idle();
        wb_LLbit_value = 1'b0;
        expect_val("ll_hold", 32'd1);
        tick(); check(DW'(LLbit_o));
        @(negedge clk); idle();
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
        expect_val("ll_clear", 32'd0);
        tick(); check(DW'(LLbit_o));

        // All three updates in one cycle
        @(negedge clk); idle();
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h0000_0001;
        wb_whilo = 1'b1; wb_hi = 32'h0BAD_0001; wb_lo = 32'h0BAD_0002;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        tick();
        @(negedge clk); idle();
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        expect_val("combo_r3", 32'h0000_0001); check(rdata1);
        expect_val("combo_hi", 32'h0BAD_0001); check(hi_o);
        expect_val("combo_lo", 32'h0BAD_0002); check(lo_o);
        expect_val("combo_ll", 32'd1); check(DW'(LLbit_o));

        // Mid-stream reset: pending write-back is lost, state zeroed
        @(negedge clk);
        rst = 1'b1;
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h0000_0099;
        wb_whilo = 1'b1; wb_hi = 32'h1357_9BDF; wb_lo = 32'h2468_ACE0;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        expect_val("midrst_rd1", '0); check(rdata1);
        expect_val("midrst_rd2", '0); check(rdata2);
        tick();
        @(negedge clk); idle();
        #1;
        expect_val("post_rst_hi", '0); check(hi_o);
        expect_val("post_rst_lo", '0); check(lo_o);
        expect_val("post_rst_ll", '0); check(DW'(LLbit_o));
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); idle();
            re1 = 1'b1; raddr1 = AW'(i); re2 = 1'b1; raddr2 = AW'(31 - i);
            #1;
            expect_val("post_rst_rd1", '0); check(rdata1);
            expect_val("post_rst_rd2", '0); check(rdata2);
        end

        // First write after reset is honoured
        @(negedge clk); idle();
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h0000_CAFE;
        tick();
        @(negedge clk); idle();
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        expect_val("first_write_r3", 32'h0000_CAFE); check(rdata1);

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover observed=%0d required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
